button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Parameters
REQ-001 SHALL provide parameter N, default 4, number of independent button channels (N >= 1).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 1000, consecutive stable cycles required to accept a level change (>= 1).
REQ-003 SHALL provide parameter REPEAT_DELAY, default 50000, cycles of continuous hold before the first auto-repeat pulse (>= 1).
REQ-004 SHALL provide parameter REPEAT_RATE, default 10000, cycles between subsequent auto-repeat pulses (>= 1).

Interface
REQ-005 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-007 SHALL have buttonin, input, N, raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have repeat_en, input, 1, synchronous auto-repeat enable, common to all channels.
REQ-009 SHALL have level, output, N, registered debounced button state.
REQ-010 SHALL have pressed, output, N, one-cycle pulse per accepted press and per auto-repeat.
REQ-011 SHALL have released, output, N, one-cycle pulse per accepted release.
REQ-012 SHALL have any_pressed, output, 1, registered OR of the next-cycle pressed vector, aligned with pressed.

Function
REQ-013 SHALL pass each buttonin bit through a 2-flop synchronizer before any other logic.
REQ-014 SHALL give each channel a debounce counter that increments while synchronized input != level, clears to 0 when equal, and is wide enough for DEBOUNCE_CYCLES.
REQ-015 SHALL toggle level[i] and clear its counter on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-016 SHALL fix latency: buttonin[i] first sampled 1 at edge k and held stable -> level[i] and pressed[i] high after edge k+DEBOUNCE_CYCLES+2.
REQ-017 SHALL reject bounce: any reversion shorter than DEBOUNCE_CYCLES clears the counter, with no change to level or pulses.
REQ-018 SHALL assert pressed[i] for exactly one cycle on a level[i] 0->1 transition, and released[i] for exactly one cycle on a 1->0 transition.
REQ-019 SHALL implement per-channel repeat FSM states IDLE, WAIT_DELAY, REPEATING.
REQ-020 SHALL transition IDLE->WAIT_DELAY on the press pulse when repeat_en=1; the repeat counter starts at 0.
REQ-021 SHALL, in WAIT_DELAY, fire a pressed pulse and enter REPEATING when the counter reaches REPEAT_DELAY cycles after the press pulse.
REQ-022 SHALL, in REPEATING, fire a pressed pulse every REPEAT_RATE cycles.
REQ-023 SHALL return any state to IDLE with the repeat counter cleared when level[i] falls; no pressed pulse occurs in the release cycle.
REQ-024 SHALL, when repeat_en deasserts, force IDLE immediately with no further repeat pulses.
REQ-025 SHALL, when repeat_en asserts while level[i]=1 in IDLE, enter WAIT_DELAY with the full REPEAT_DELAY restarting.
REQ-026 SHALL never assert pressed[i] and released[i] in the same cycle.
REQ-027 SHALL keep channels fully independent; simultaneous events on several channels all produce pulses in the same cycle.

Reset
REQ-028 SHALL, while rst_n=0, clear synchronizers, level, counters and pressed/released/any_pressed to 0, and force all FSMs to IDLE.
REQ-029 SHALL, after rst_n deasserts with a button held, require a fresh full debounce before that press is reported; no pulse may be lost or duplicated due to reset.

Verification (N=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-030 SHALL cover clean press: buttonin[0] 0->1 sampled at edge 10 -> level[0] and a 1-cycle pressed[0] after edge 16, any_pressed aligned.
REQ-031 SHALL cover bounce: buttonin[1] high for 3 cycles, low 1, high 3 -> no level or pulse change; then held 4+ cycles -> single pressed[1].
REQ-032 SHALL cover repeat: repeat_en=1, hold ch2 -> pressed at P, P+10, P+13, P+16; release -> released[2] only, no further pulses.
REQ-033 SHALL cover repeat_en dropped at P+11 -> no pulse at P+13; re-raised at P+20 while held -> next pulse at P+30.
REQ-034 SHALL cover simultaneous events: ch0 press and ch3 release debounced on the same edge -> pressed=0001, released=1000 in one cycle.
REQ-035 SHALL cover reset mid-hold: rst_n low for 2 cycles with ch1 held -> outputs 0; after release of reset, pressed[1] DEBOUNCE_CYCLES+2 edges later, once.

Source files
------------

// File: rtl/button_if.sv
// Button conditioner bus: raw button levels and repeat enable toward the
// conditioner, debounced level and event pulses back to the consumer.
interface button_if #(
    parameter int N = 4
);
    logic [N-1:0] buttonin;
    logic         repeat_en;
    logic [N-1:0] level;
    logic [N-1:0] pressed;
    logic [N-1:0] released;
    logic         any_pressed;

    modport master (
        output buttonin,
        output repeat_en,
        input  level,
        input  pressed,
        input  released,
        input  any_pressed
    );

    modport slave (
        input  buttonin,
        input  repeat_en,
        output level,
        output pressed,
        output released,
        output any_pressed
    );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-flop synchronizer, per-channel
// debounce counter, press/release pulse generation and a per-channel
// auto-repeat FSM. The debounced state is held one stage ahead of the
// registered level output, so a press is visible DEBOUNCE_CYCLES+2 edges
// after the first sampled edge and the repeat FSM reacts in the same cycle
// that the press/release pulse is being formed.
module button_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_RATE     = 10000
) (
    input  logic     clk,
    input  logic     rst_n,
    button_if.slave  bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_DELAY = 2'd1,
        ST_REPEATING  = 2'd2
    } rpt_state_t;

    logic [N-1:0]     sync1_r;
    logic [N-1:0]     sync2_r;
    logic [N-1:0]     db_r;
    logic [DB_W-1:0]  db_cnt_r [N];

    logic [N-1:0]     level_r;
    logic [N-1:0]     pressed_r;
    logic [N-1:0]     released_r;
    logic             any_pressed_r;

    rpt_state_t       state_r     [N];
    rpt_state_t       state_nxt_s [N];
    logic [RPT_W-1:0] rpt_cnt_r     [N];
    logic [RPT_W-1:0] rpt_cnt_nxt_s [N];

    logic [N-1:0]     rise_s;
    logic [N-1:0]     fall_s;
    logic [N-1:0]     fire_s;
    logic [N-1:0]     pressed_nxt_s;
    logic [N-1:0]     released_nxt_s;

    // Two-flop synchronizer for the asynchronous button levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {N{1'b0}};
            sync2_r <= {N{1'b0}};
        end else begin
            sync1_r <= bus.buttonin;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip state on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_r <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                    db_r[i]     <= ~db_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Edge detection between the debounced state and the registered level.
    always_comb begin
        rise_s = db_r & ~level_r;
        fall_s = ~db_r & level_r;
    end

    // Repeat FSM state register and repeat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                state_r[i]   <= ST_IDLE;
                rpt_cnt_r[i] <= {RPT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                state_r[i]   <= state_nxt_s[i];
                rpt_cnt_r[i] <= rpt_cnt_nxt_s[i];
            end
        end
    end

    // Repeat FSM next state; a released button or disabled repeat forces IDLE.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_nxt_s[i] = state_r[i];
            if (!bus.repeat_en || !db_r[i]) begin
                state_nxt_s[i] = ST_IDLE;
            end else begin
                case (state_r[i])
                    ST_IDLE: begin
                        state_nxt_s[i] = ST_WAIT_DELAY;
                    end
                    ST_WAIT_DELAY: begin
                        if (rpt_cnt_r[i] == DELAY_LAST) begin
                            state_nxt_s[i] = ST_REPEATING;
                        end else begin
                            state_nxt_s[i] = ST_WAIT_DELAY;
                        end
                    end
                    ST_REPEATING: begin
                        state_nxt_s[i] = ST_REPEATING;
                    end
                    default: begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Repeat FSM outputs: repeat pulse request and next counter value.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            fire_s[i]        = 1'b0;
            rpt_cnt_nxt_s[i] = {RPT_W{1'b0}};
            if (!bus.repeat_en || !db_r[i]) begin
                fire_s[i]        = 1'b0;
                rpt_cnt_nxt_s[i] = {RPT_W{1'b0}};
            end else begin
                case (state_r[i])
                    ST_IDLE: begin
                        rpt_cnt_nxt_s[i] = {RPT_W{1'b0}};
                    end
                    ST_WAIT_DELAY: begin
                        if (rpt_cnt_r[i] == DELAY_LAST) begin
                            fire_s[i]        = 1'b1;
                            rpt_cnt_nxt_s[i] = {RPT_W{1'b0}};
                        end else begin
                            rpt_cnt_nxt_s[i] = rpt_cnt_r[i] + RPT_W'(1);
                        end
                    end
                    ST_REPEATING: begin
                        if (rpt_cnt_r[i] == RATE_LAST) begin
                            fire_s[i]        = 1'b1;
                            rpt_cnt_nxt_s[i] = {RPT_W{1'b0}};
                        end else begin
                            rpt_cnt_nxt_s[i] = rpt_cnt_r[i] + RPT_W'(1);
                        end
                    end
                    default: begin
                        rpt_cnt_nxt_s[i] = {RPT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Pulse vectors feeding the output registers.
    always_comb begin
        pressed_nxt_s  = rise_s | fire_s;
        released_nxt_s = fall_s;
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r       <= {N{1'b0}};
            pressed_r     <= {N{1'b0}};
            released_r    <= {N{1'b0}};
            any_pressed_r <= 1'b0;
        end else begin
            level_r       <= db_r;
            pressed_r     <= pressed_nxt_s;
            released_r    <= released_nxt_s;
            any_pressed_r <= |pressed_nxt_s;
        end
    end

    assign bus.level       = level_r;
    assign bus.pressed     = pressed_r;
    assign bus.released    = released_r;
    assign bus.any_pressed = any_pressed_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed, table-driven bench for button_conditioner with
// N=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    button_if #(.N(N)) bus ();

    button_conditioner #(
        .N              (N),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // One vector: drive btn/ren, advance n edges. Intermediate edges must show
    // the same level and no pulses; the last edge shows lvl/prs/rel.
    typedef struct {
        logic [3:0] btn;
        logic       ren;
        int         n;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    task automatic add(input logic [3:0] btn, input logic ren, input int n,
                       input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
        vec_t v;
        v.btn = btn; v.ren = ren; v.n = n; v.lvl = lvl; v.prs = prs; v.rel = rel;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%b expected=%b", nm, idx, act, exp);
        end
    endtask

    initial begin
        int pcount;
        int pidx;
        int rcount;

        bus.buttonin  = 4'b0000;
        bus.repeat_en = 1'b0;
        rst_n         = 1'b0;

        // clean press/release on ch0
        add(4'b0001, 1'b0, 6, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 1'b0, 1, 4'b0001, 4'b0001, 4'b0000);
        add(4'b0001, 1'b0, 1, 4'b0001, 4'b0000, 4'b0000);
        add(4'b0001, 1'b0, 3, 4'b0001, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 6, 4'b0001, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0001);
        add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0000);
        // bounce on ch1, then a steady hold
        add(4'b0010, 1'b0, 3, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0010, 1'b0, 3, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0010, 1'b0, 6, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0010, 1'b0, 1, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0010, 1'b0, 2, 4'b0010, 4'b0000, 4'b0000);
        // ch3 press, then ch3 release and ch0 press on the same edge
        add(4'b1010, 1'b0, 6, 4'b0010, 4'b0000, 4'b0000);
        add(4'b1010, 1'b0, 1, 4'b1010, 4'b1000, 4'b0000);
        add(4'b0011, 1'b0, 6, 4'b1010, 4'b0000, 4'b0000);
        add(4'b0011, 1'b0, 1, 4'b0011, 4'b0001, 4'b1000);
        add(4'b0011, 1'b0, 1, 4'b0011, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 6, 4'b0011, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0011);
        add(4'b0000, 1'b0, 2, 4'b0000, 4'b0000, 4'b0000);
        // auto-repeat on ch2: pulses at P, P+10, P+13, P+16, P+19, P+22
        add(4'b0100, 1'b1, 6, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0100, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 1'b1, 9, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0100, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 1'b1, 2, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0100, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 1'b1, 2, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0100, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        // release sampled at P+17; level still high until P+23
        add(4'b0000, 1'b1, 2, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0000, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0000, 1'b1, 2, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0000, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0000, 1'b1, 1, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0000, 1'b1, 8, 4'b0000, 4'b0000, 4'b0000);
        // repeat_en dropped for P+11..P+19, raised at P+20 -> next pulse P+30
        add(4'b0100, 1'b1, 6, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0100, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 1'b1, 9, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0100, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 1'b0, 9, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0100, 1'b1, 10, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0100, 1'b1, 1, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 1'b0, 1, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 6, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 1, 4'b0000, 4'b0000, 4'b0100);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", -1, bus.level, 4'b0000);
        chk("rst_pressed", -1, bus.pressed, 4'b0000);
        chk("rst_released", -1, bus.released, 4'b0000);
        chk("rst_any", -1, {3'b000, bus.any_pressed}, 4'b0000);
        rst_n = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            bus.buttonin  = vecs[v].btn;
            bus.repeat_en = vecs[v].ren;
            for (int j = 0; j < vecs[v].n; j++) begin
                @(posedge clk);
                #1;
                if (j < vecs[v].n - 1) begin
                    chk("mid_level", v, bus.level, vecs[v].lvl);
                    chk("mid_pulses", v, bus.pressed | bus.released, 4'b0000);
                end else begin
                    chk("level", v, bus.level, vecs[v].lvl);
                    chk("pressed", v, bus.pressed, vecs[v].prs);
                    chk("released", v, bus.released, vecs[v].rel);
                    chk("any_pressed", v, {3'b000, bus.any_pressed}, {3'b000, |vecs[v].prs});
                end
            end
        end

        // reset while ch1 is held: outputs clear, then one fresh press after DB+2 edges
        bus.buttonin  = 4'b0010;
        bus.repeat_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("hold_level", 100, bus.level, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("rst2_level", 100, bus.level, 4'b0000);
        chk("rst2_pressed", 100, bus.pressed, 4'b0000);
        chk("rst2_released", 100, bus.released, 4'b0000);
        chk("rst2_any", 100, {3'b000, bus.any_pressed}, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst2_hold_level", 100, bus.level, 4'b0000);
        rst_n  = 1'b1;
        pcount = 0;
        pidx   = -1;
        rcount = 0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk);
            #1;
            if (bus.pressed[1]) begin
                pcount++;
                pidx = e;
            end
            if (bus.released != 4'b0000) begin
                rcount++;
            end
        end
        chk("rst2_press_count", 101, pcount[3:0], 4'd1);
        chk("rst2_press_edge", 101, pidx[3:0], 4'(DB + 2));
        chk("rst2_release_count", 101, rcount[3:0], 4'd0);
        chk("rst2_final_level", 101, bus.level, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
